// File: rtl/fft_pwr_pkg.sv
// fft_pwr_pkg: shared states, default sizes and helpers for the FFT bin power
// integrator.
package fft_pwr_pkg;

   typedef enum logic [1:0] {SYNC, COLLECT, DUMP} pwr_state_t;

   localparam int unsigned NBINS_DEF = 8;
   localparam int unsigned DW_DEF    = 16;

   typedef logic signed [DW_DEF-1:0] cplx_comp_t;

   // |X|^2 of one complex sample at the default component width.
   function automatic logic [2*DW_DEF:0] sq_mag(input cplx_comp_t re, input cplx_comp_t im);
      logic signed [2*DW_DEF-1:0] re2;
      logic signed [2*DW_DEF-1:0] im2;
      re2 = (2*DW_DEF)'(re) * (2*DW_DEF)'(re);
      im2 = (2*DW_DEF)'(im) * (2*DW_DEF)'(im);
      return {1'b0, re2} + {1'b0, im2};
   endfunction

endpackage

// File: rtl/fft_pwr_mag_sq.sv
// fft_pwr_mag_sq: two-stage registered squaring pipe (S1 capture, S2 squares)
// with valid and bin index carried alongside the data.
module fft_pwr_mag_sq
   import fft_pwr_pkg::*;
#(
   parameter int unsigned DW = DW_DEF,
   parameter int unsigned BW = 3
) (
   input  logic                 clk,
   input  logic                 rstn,
   input  logic                 kill,
   input  logic                 beat_valid,
   input  logic signed [DW-1:0] beat_re,
   input  logic signed [DW-1:0] beat_im,
   input  logic [BW-1:0]        beat_bin,
   output logic                 sq_valid,
   output logic [2*DW-1:0]      re_sq,
   output logic [2*DW-1:0]      im_sq,
   output logic [BW-1:0]        sq_bin
);

   logic                 s1_valid;
   logic signed [DW-1:0] s1_re;
   logic signed [DW-1:0] s1_im;
   logic [BW-1:0]        s1_bin;
   logic signed [2*DW-1:0] re_prod;
   logic signed [2*DW-1:0] im_prod;

   always_comb begin
      re_prod = (2*DW)'(s1_re) * (2*DW)'(s1_re);
      im_prod = (2*DW)'(s1_im) * (2*DW)'(s1_im);
   end

   // A restarting beat may enter S1 in the same cycle older beats are killed.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         s1_valid <= 1'b0;
         s1_re    <= '0;
         s1_im    <= '0;
         s1_bin   <= '0;
         sq_valid <= 1'b0;
         re_sq    <= '0;
         im_sq    <= '0;
         sq_bin   <= '0;
      end else begin
         s1_valid <= beat_valid;
         if (beat_valid) begin
            s1_re  <= beat_re;
            s1_im  <= beat_im;
            s1_bin <= beat_bin;
         end
         sq_valid <= s1_valid && !kill;
         re_sq    <= unsigned'(re_prod);
         im_sq    <= unsigned'(im_prod);
         sq_bin   <= s1_bin;
      end
   end

endmodule

// File: rtl/fft_bin_power_acc.sv
// fft_bin_power_acc: per-bin |X[k]|^2 integrated over INT_FRAMES FFT frames.
// Optional macro FFT_PWR_SATURATE_EN: accumulators saturate instead of wrapping.
module fft_bin_power_acc
   import fft_pwr_pkg::*;
#(
   parameter int unsigned NBINS      = NBINS_DEF,
   parameter int unsigned DW         = DW_DEF,
   parameter int unsigned ACC_W      = 40,
   parameter int unsigned INT_FRAMES = 4
) (
   input  logic                     clk,
   input  logic                     rstn,
   input  logic [2*DW-1:0]          fft_tdata,
   input  logic [$clog2(NBINS)-1:0] fft_tuser,
   input  logic                     fft_tvalid,
   input  logic                     err_clr,
   output logic [ACC_W-1:0]         pwr_out [NBINS],
   output logic                     pwr_valid,
   output logic                     frame_err,
   output logic [7:0]               frame_cnt
);

   localparam int unsigned BW         = $clog2(NBINS);
   localparam int unsigned SW         = 2*DW + 1;
   localparam logic [BW-1:0] LAST_BIN = BW'(NBINS - 1);
   localparam logic [7:0] LAST_FRAME  = 8'(INT_FRAMES - 1);

   pwr_state_t state, state_nxt;
   logic [BW-1:0] exp_bin, exp_bin_nxt;
   logic          accept;
   logic          seq_err;

   logic            sq_valid;
   logic [2*DW-1:0] re_sq;
   logic [2*DW-1:0] im_sq;
   logic [BW-1:0]   sq_bin;
   logic [SW-1:0]   pwr_sum;
   logic            frame_done;
   logic            window_done;

   logic [ACC_W-1:0] acc     [NBINS];
   logic [ACC_W-1:0] acc_add [NBINS];
   logic [NBINS-1:0] hit;
`ifdef FFT_PWR_SATURATE_EN
   logic [ACC_W:0]   acc_wide [NBINS];
`endif

   fft_pwr_mag_sq #(.DW(DW), .BW(BW)) u_mag_sq (
      .clk        (clk),
      .rstn       (rstn),
      .kill       (seq_err),
      .beat_valid (accept),
      .beat_re    (fft_tdata[DW-1:0]),
      .beat_im    (fft_tdata[2*DW-1:DW]),
      .beat_bin   (fft_tuser),
      .sq_valid   (sq_valid),
      .re_sq      (re_sq),
      .im_sq      (im_sq),
      .sq_bin     (sq_bin)
   );

   assign pwr_sum     = SW'(re_sq) + SW'(im_sq);
   assign frame_done  = sq_valid && (sq_bin == LAST_BIN);
   assign window_done = frame_done && (frame_cnt == LAST_FRAME);

   // Input sequencing runs at the pipe entrance; DUMP is keyed off the pipe exit.
   always_comb begin
      state_nxt   = state;
      exp_bin_nxt = exp_bin;
      accept      = 1'b0;
      seq_err     = 1'b0;
      case (state)
         SYNC: begin
            if (fft_tvalid && fft_tuser == '0) begin
               accept      = 1'b1;
               state_nxt   = COLLECT;
               exp_bin_nxt = BW'(1);
            end
         end
         default: begin
            if (state == DUMP) state_nxt = COLLECT;
            if (fft_tvalid) begin
               if (fft_tuser == exp_bin) begin
                  accept      = 1'b1;
                  exp_bin_nxt = exp_bin + BW'(1);
               end else begin
                  seq_err = 1'b1;
                  if (fft_tuser == '0) begin
                     accept      = 1'b1;
                     state_nxt   = COLLECT;
                     exp_bin_nxt = BW'(1);
                  end else begin
                     state_nxt = SYNC;
                  end
               end
            end
         end
      endcase
      if (window_done && !seq_err) state_nxt = DUMP;
   end

   always_comb begin
      for (int unsigned k = 0; k < NBINS; k++) begin
         hit[k] = sq_valid && (sq_bin == BW'(k));
`ifdef FFT_PWR_SATURATE_EN
         acc_wide[k] = {1'b0, acc[k]} + (ACC_W+1)'(pwr_sum);
         acc_add[k]  = acc_wide[k][ACC_W] ? '1 : acc_wide[k][ACC_W-1:0];
`else
         acc_add[k]  = acc[k] + ACC_W'(pwr_sum);
`endif
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state     <= SYNC;
         exp_bin   <= '0;
         frame_cnt <= '0;
         frame_err <= 1'b0;
         pwr_valid <= 1'b0;
         for (int unsigned k = 0; k < NBINS; k++) begin
            acc[k]     <= '0;
            pwr_out[k] <= '0;
         end
      end else begin
         state     <= state_nxt;
         exp_bin   <= exp_bin_nxt;
         pwr_valid <= 1'b0;
         if (seq_err)
            frame_err <= 1'b1;
         else if (err_clr)
            frame_err <= 1'b0;

         if (seq_err) begin
            for (int unsigned k = 0; k < NBINS; k++) acc[k] <= '0;
            frame_cnt <= '0;
         end else if (state == DUMP) begin
            // Clear starts the new window with any bin landing this same cycle.
            pwr_valid <= 1'b1;
            for (int unsigned k = 0; k < NBINS; k++) begin
               pwr_out[k] <= acc[k];
               acc[k]     <= hit[k] ? ACC_W'(pwr_sum) : '0;
            end
            frame_cnt <= frame_done ? 8'd1 : 8'd0;
         end else begin
            for (int unsigned k = 0; k < NBINS; k++)
               if (hit[k]) acc[k] <= acc_add[k];
            if (frame_done) frame_cnt <= frame_cnt + 8'd1;
         end
      end
   end

endmodule

// File: tb/tb_fft_bin_power_acc.sv
// Directed table-driven bench for fft_bin_power_acc (default build plus an
// ACC_W=32 instance for the overflow / FFT_PWR_SATURATE_EN case).
module tb_fft_bin_power_acc;

   localparam int NB = 8;

   typedef struct {
      logic signed [15:0] re;
      logic signed [15:0] im;
      logic [39:0]        pwr;
   } vec_t;

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic [31:0] fft_tdata = '0;
   logic [2:0]  fft_tuser = '0;
   logic        fft_tvalid = 1'b0;
   logic        err_clr = 1'b0;

   logic [39:0] pwr_out [NB];
   logic        pwr_valid;
   logic        frame_err;
   logic [7:0]  frame_cnt;
   logic [31:0] pwr_out32 [NB];
   logic        pwr_valid32;
   logic        frame_err32;
   logic [7:0]  frame_cnt32;

   int total = 0;
   int bad = 0;
   int valid_cnt = 0;
   int valid_cnt32 = 0;
   logic [39:0] cap [NB];
   logic [31:0] cap32 [NB];
   vec_t tbl [3][NB];

   always #5 clk = ~clk;

   fft_bin_power_acc #(.NBINS(8), .DW(16), .ACC_W(40), .INT_FRAMES(4)) dut (
      .clk(clk), .rstn(rstn), .fft_tdata(fft_tdata), .fft_tuser(fft_tuser),
      .fft_tvalid(fft_tvalid), .err_clr(err_clr), .pwr_out(pwr_out),
      .pwr_valid(pwr_valid), .frame_err(frame_err), .frame_cnt(frame_cnt)
   );

   fft_bin_power_acc #(.NBINS(8), .DW(16), .ACC_W(32), .INT_FRAMES(4)) dut32 (
      .clk(clk), .rstn(rstn), .fft_tdata(fft_tdata), .fft_tuser(fft_tuser),
      .fft_tvalid(fft_tvalid), .err_clr(err_clr), .pwr_out(pwr_out32),
      .pwr_valid(pwr_valid32), .frame_err(frame_err32), .frame_cnt(frame_cnt32)
   );

   always @(negedge clk) begin
      if (pwr_valid) begin
         valid_cnt <= valid_cnt + 1;
         for (int k = 0; k < NB; k++) cap[k] <= pwr_out[k];
      end
      if (pwr_valid32) begin
         valid_cnt32 <= valid_cnt32 + 1;
         for (int k = 0; k < NB; k++) cap32[k] <= pwr_out32[k];
      end
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic idle(input int n);
      fft_tvalid = 1'b0;
      repeat (n) @(negedge clk);
   endtask

   task automatic beat(input int bin, input logic signed [15:0] re, input logic signed [15:0] im);
      fft_tvalid = 1'b1;
      fft_tuser  = 3'(bin);
      fft_tdata  = {im, re};
      @(negedge clk);
      fft_tvalid = 1'b0;
   endtask

   // Sends the rest of a 4-frame window from (frame 0, bin first_k), waits for
   // the strobe and checks the captured powers against table sel.
   task automatic run_window(input int sel, input bit gaps, input string name,
                             input int first_k, input logic exp_err);
      int start;
      start = valid_cnt;
      for (int f = 0; f < 4; f++)
         for (int k = (f == 0) ? first_k : 0; k < NB; k++) begin
            beat(k, tbl[sel][k].re, tbl[sel][k].im);
            if (gaps) idle($urandom_range(0, 3));
         end
      for (int i = 0; i < 30; i++) begin
         if (valid_cnt != start) break;
         @(negedge clk);
      end
      idle(6);
      chk({name, "_one_valid"}, 64'(valid_cnt), 64'(start + 1));
      for (int k = 0; k < NB; k++)
         chk($sformatf("%s_pwr%0d", name, k), 64'(cap[k]), 64'(tbl[sel][k].pwr));
      chk({name, "_err"}, 64'(frame_err), 64'(exp_err));
      chk({name, "_cnt"}, 64'(frame_cnt), 64'd0);
   endtask

   initial begin
      int s0;
      int s32;
      logic [31:0] exp32;

      // Table 0: real k+1, imag 0 -> 4*(k+1)^2
      for (int k = 0; k < NB; k++) begin
         tbl[0][k].re  = 16'(k + 1);
         tbl[0][k].im  = 16'sd0;
         tbl[0][k].pwr = 40'(4 * (k + 1) * (k + 1));
      end
      // Table 1: mixed signs and extremes, pwr = 4*(re^2+im^2)
      tbl[1][0] = '{16'sd3,      16'sd4,      40'd100};
      tbl[1][1] = '{-16'sd3,     -16'sd4,     40'd100};
      tbl[1][2] = '{16'sd0,      -16'sd1,     40'd4};
      tbl[1][3] = '{-16'sd32768, 16'sd0,      40'h01_0000_0000};
      tbl[1][4] = '{16'sd32767,  16'sd32767,  40'h01_FFF8_0008};
      tbl[1][5] = '{16'sd1,      -16'sd1,     40'd8};
      tbl[1][6] = '{-16'sd100,   16'sd7,      40'd40196};
      tbl[1][7] = '{16'sd255,    -16'sd256,   40'd522244};
      // Table 2: full-scale negative on both components -> 2^33
      for (int k = 0; k < NB; k++)
         tbl[2][k] = '{-16'sd32768, -16'sd32768, 40'h02_0000_0000};

      // 1: reset state, then a clean back-to-back window
      repeat (2) @(negedge clk);
      chk("rst_valid", 64'(pwr_valid), 64'd0);
      chk("rst_err", 64'(frame_err), 64'd0);
      chk("rst_cnt", 64'(frame_cnt), 64'd0);
      for (int k = 0; k < NB; k++) chk($sformatf("rst_pwr%0d", k), 64'(pwr_out[k]), 64'd0);
      rstn = 1'b1;
      idle(2);
      run_window(0, 1'b0, "t1", 0, 1'b0);

      // 2: same data with random gaps
      run_window(0, 1'b1, "t2", 0, 1'b0);

      // extra: signed / extreme values
      run_window(1, 1'b0, "tsign", 0, 1'b0);

      // 3: sequence error in frame 2 (bins 0,1,2,5)
      s0 = valid_cnt;
      for (int f = 0; f < 2; f++)
         for (int k = 0; k < NB; k++) beat(k, tbl[0][k].re, tbl[0][k].im);
      idle(4);
      chk("t3_cnt_before", 64'(frame_cnt), 64'd2);
      beat(0, 16'sd9, 16'sd0);
      beat(1, 16'sd9, 16'sd0);
      beat(2, 16'sd9, 16'sd0);
      beat(5, 16'sd9, 16'sd0);
      idle(5);
      chk("t3_err", 64'(frame_err), 64'd1);
      chk("t3_cnt", 64'(frame_cnt), 64'd0);
      chk("t3_no_valid", 64'(valid_cnt), 64'(s0));
      for (int k = 0; k < NB; k++)
         chk($sformatf("t3_hold%0d", k), 64'(pwr_out[k]), 64'(tbl[1][k].pwr));
      // junk in SYNC must be discarded before the resync on bin 0
      beat(3, 16'sd50, 16'sd50);
      beat(4, 16'sd50, 16'sd50);
      run_window(0, 1'b0, "t3_resync", 0, 1'b1);
      err_clr = 1'b1;
      idle(1);
      err_clr = 1'b0;
      idle(1);
      chk("t3_clr", 64'(frame_err), 64'd0);

      // 4: full-scale window, 40-bit exact and 32-bit overflow behaviour
      s32 = valid_cnt32;
      run_window(2, 1'b0, "t4", 0, 1'b0);
`ifdef FFT_PWR_SATURATE_EN
      exp32 = 32'hFFFF_FFFF;
`else
      exp32 = 32'h0;
`endif
      chk("t4_valid32", 64'(valid_cnt32), 64'(s32 + 1));
      for (int k = 0; k < NB; k++)
         chk($sformatf("t4_pwr32_%0d", k), 64'(cap32[k]), 64'(exp32));

      // 5: reset in the middle of frame 2
      for (int f = 0; f < 2; f++)
         for (int k = 0; k < NB; k++) beat(k, tbl[0][k].re, tbl[0][k].im);
      for (int k = 0; k < 4; k++) beat(k, tbl[0][k].re, tbl[0][k].im);
      #2 rstn = 1'b0;
      #1;
      chk("t5_valid", 64'(pwr_valid), 64'd0);
      chk("t5_err", 64'(frame_err), 64'd0);
      chk("t5_cnt", 64'(frame_cnt), 64'd0);
      for (int k = 0; k < NB; k++) chk($sformatf("t5_pwr%0d", k), 64'(pwr_out[k]), 64'd0);
      idle(2);
      rstn = 1'b1;
      idle(1);
      for (int k = 4; k < NB; k++) beat(k, tbl[0][k].re, tbl[0][k].im);
      run_window(1, 1'b0, "t5_after", 0, 1'b0);

      // 6: error with err_clr in the same cycle; offending bin 0 restarts a frame
      beat(0, 16'sd7, 16'sd7);
      beat(1, 16'sd7, 16'sd7);
      beat(3, 16'sd7, 16'sd7);
      idle(3);
      chk("t6_err_first", 64'(frame_err), 64'd1);
      beat(0, 16'sd11, 16'sd0);
      beat(1, 16'sd11, 16'sd0);
      beat(2, 16'sd11, 16'sd0);
      err_clr = 1'b1;
      beat(0, tbl[0][0].re, tbl[0][0].im);
      err_clr = 1'b0;
      chk("t6_set_wins", 64'(frame_err), 64'd1);
      run_window(0, 1'b0, "t6_restart", 1, 1'b1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
